// File: rtl/jt51_pm_pkg.sv
// jt51_pm_pkg: constants, key-code threshold tables and slot bundles
// shared by the JT51 pitch-modulation pipeline.
package jt51_pm_pkg;

    localparam int KCEX_W   = 13;
    localparam int MOD_W    = 9;
    localparam int CH_MAX_W = 5;

    localparam logic [KCEX_W-1:0] KCEX_MAX = 13'h1FBF;

    // add-path note-gap thresholds, indexed by kcin[1:0]
    localparam logic [9:0] ADD_T03_2 = 10'd448;
    localparam logic [9:0] ADD_T03_1 = 10'd256;
    localparam logic [9:0] ADD_T1_2  = 10'd384;
    localparam logic [9:0] ADD_T1_1  = 10'd192;
    localparam logic [9:0] ADD_T2_3  = 10'd512;
    localparam logic [9:0] ADD_T2_2  = 10'd320;
    localparam logic [9:0] ADD_T2_1  = 10'd128;

    localparam logic [9:0] SUB_T03_3 = 10'd449;
    localparam logic [9:0] SUB_T03_2 = 10'd257;
    localparam logic [9:0] SUB_T03_1 = 10'd65;
    localparam logic [9:0] SUB_T1_2  = 10'd321;
    localparam logic [9:0] SUB_T1_1  = 10'd129;
    localparam logic [9:0] SUB_T2_2  = 10'd385;
    localparam logic [9:0] SUB_T2_1  = 10'd193;

    typedef struct packed {
        logic                valid;
        logic [CH_MAX_W-1:0] ch;
        logic [6:0]          kcin;
        logic                carry;
        logic [5:0]          kf;
        logic [MOD_W-1:0]    mod;
        logic                add;
    } pm_slot_t;

    typedef struct packed {
        logic                valid;
        logic [CH_MAX_W-1:0] ch;
        logic                carry;
        logic                add;
        logic [13:0]         sum;
        logic [13:0]         diff;
    } pm_res_t;

    function automatic logic [1:0] add_extra(
        input logic [1:0] note,
        input logic [9:0] lim
    );
        logic [1:0] e;
        e = 2'd0;
        case (note)
            2'd1: begin
                if (lim >= ADD_T1_2)      e = 2'd2;
                else if (lim >= ADD_T1_1) e = 2'd1;
            end
            2'd2: begin
                if (lim >= ADD_T2_3)      e = 2'd3;
                else if (lim >= ADD_T2_2) e = 2'd2;
                else if (lim >= ADD_T2_1) e = 2'd1;
            end
            default: begin
                if (lim >= ADD_T03_2)      e = 2'd2;
                else if (lim >= ADD_T03_1) e = 2'd1;
            end
        endcase
        return e;
    endfunction

    // slim is signed; a negative margin never crosses a note gap
    function automatic logic [1:0] sub_extra(
        input logic [1:0] note,
        input logic [9:0] slim
    );
        logic [1:0] e;
        e = 2'd0;
        if (!slim[9]) begin
            case (note)
                2'd1: begin
                    if (slim >= SUB_T1_2)      e = 2'd2;
                    else if (slim >= SUB_T1_1) e = 2'd1;
                end
                2'd2: begin
                    if (slim >= SUB_T2_2)      e = 2'd2;
                    else if (slim >= SUB_T2_1) e = 2'd1;
                end
                default: begin
                    if (slim >= SUB_T03_3)      e = 2'd3;
                    else if (slim >= SUB_T03_2) e = 2'd2;
                    else if (slim >= SUB_T03_1) e = 2'd1;
                end
            endcase
        end
        return e;
    endfunction

endpackage

// File: rtl/jt51_pm_buf.sv
// jt51_pm_buf: per-channel kcex result buffer, combinational read.
// With JT51_PM_SAT_FLAG_EN it also keeps a sticky per-channel sat bit.
module jt51_pm_buf
    import jt51_pm_pkg::*;
#(
    parameter  int CHANNELS = 8,
    localparam int CHW      = $clog2(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [KCEX_W-1:0] wr_kcex,
`ifdef JT51_PM_SAT_FLAG_EN
    input  logic              wr_sat,
    output logic              rd_sat,
`endif
    input  logic [CHW-1:0]    rd_ch,
    output logic [KCEX_W-1:0] rd_kcex
);

    localparam logic [CHW:0] NCH = (CHW+1)'(CHANNELS);

    logic [KCEX_W-1:0] mem [CHANNELS];
`ifdef JT51_PM_SAT_FLAG_EN
    logic [CHANNELS-1:0] sat_mem;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                mem[i] <= '0;
            end
`ifdef JT51_PM_SAT_FLAG_EN
            sat_mem <= '0;
`endif
        end else if (wr_en) begin
            mem[wr_ch] <= wr_kcex;
`ifdef JT51_PM_SAT_FLAG_EN
            sat_mem[wr_ch] <= sat_mem[wr_ch] | wr_sat;
`endif
        end
    end

    // a power-of-two depth has no unused read codes to decode
    generate
        if (CHANNELS == (1 << CHW)) begin : g_full
            assign rd_kcex = mem[rd_ch];
`ifdef JT51_PM_SAT_FLAG_EN
            assign rd_sat  = sat_mem[rd_ch];
`endif
        end else begin : g_part
            logic rd_ok;
            assign rd_ok   = ({1'b0, rd_ch} < NCH);
            assign rd_kcex = rd_ok ? mem[rd_ch] : '0;
`ifdef JT51_PM_SAT_FLAG_EN
            assign rd_sat  = rd_ok ? sat_mem[rd_ch] : 1'b0;
`endif
        end
    endgenerate

endmodule

// File: rtl/jt51_pm_pipe.sv
// jt51_pm_pipe: 3-stage time-multiplexed pitch modulation producing kcex.
// Optional JT51_PM_SAT_FLAG_EN adds the sat and rd_sat flag outputs.
module jt51_pm_pipe
    import jt51_pm_pkg::*;
#(
    parameter  int CHANNELS  = 8,
    parameter  int PMS_SHIFT = 5,
    localparam int CHW       = $clog2(CHANNELS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cen,
    input  logic              in_valid,
    input  logic [CHW-1:0]    in_ch,
    input  logic [6:0]        kc_in,
    input  logic [5:0]        kf_in,
    input  logic [7:0]        lfo_pm,
    input  logic [2:0]        pms,
    output logic              out_valid,
    output logic [CHW-1:0]    out_ch,
    output logic [KCEX_W-1:0] kcex,
`ifdef JT51_PM_SAT_FLAG_EN
    output logic              sat,
    output logic              rd_sat,
`endif
    input  logic [CHW-1:0]    rd_ch,
    output logic [KCEX_W-1:0] rd_kcex
);

    localparam logic [CH_MAX_W:0] NCH = (CH_MAX_W+1)'(CHANNELS);

    pm_slot_t s1_d, s1_q;
    pm_res_t  s2_d, s2_q;

    logic [6:0]  mag;
    logic [13:0] mod_shl;
    logic [13:0] mod_shr;
    logic [7:0]  kc_inc;

    // S1: modulation depth, direction and key-code cleaning
    always_comb begin
        if (!lfo_pm[7])
            mag = lfo_pm[6:0];
        else if (lfo_pm == 8'h80)
            mag = 7'h7F;
        else
            mag = 7'(-lfo_pm);
        mod_shl = {7'd0, mag} << pms;
        mod_shr = mod_shl >> PMS_SHIFT;
        kc_inc  = {1'b0, kc_in} + 8'd1;

        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.ch    = CH_MAX_W'(in_ch);
        s1_d.kf    = kf_in;
        if (pms == 3'd0)
            s1_d.mod = '0;
        else if (mod_shr > 14'd511)
            s1_d.mod = '1;
        else
            s1_d.mod = mod_shr[MOD_W-1:0];
        s1_d.add = !lfo_pm[7] || (s1_d.mod == '0);
        if (kc_in[1:0] == 2'b11) begin
            {s1_d.carry, s1_d.kcin} = kc_inc;
        end else begin
            s1_d.carry = 1'b0;
            s1_d.kcin  = kc_in;
        end
    end

    logic [9:0]  lim;
    logic [9:0]  slim;
    logic [1:0]  aex;
    logic [1:0]  sex;
    logic [13:0] base;
    logic [13:0] sum0;
    logic [13:0] diff0;

    // S2: add and sub paths side by side, each skipping the note gap
    always_comb begin
        lim   = {1'b0, s1_q.mod} + {4'd0, s1_q.kf};
        slim  = {1'b0, s1_q.mod} - {4'd0, s1_q.kf};
        aex   = add_extra(s1_q.kcin[1:0], lim);
        sex   = sub_extra(s1_q.kcin[1:0], slim);
        base  = {1'b0, s1_q.kcin, s1_q.kf};
        sum0  = base + {6'd0, aex, 6'd0} + {5'd0, s1_q.mod};
        diff0 = base - {6'd0, sex, 6'd0} - {5'd0, s1_q.mod};

        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.ch    = s1_q.ch;
        s2_d.carry = s1_q.carry;
        s2_d.add   = s1_q.add;
        s2_d.sum   = (sum0[7:6] == 2'b11) ? sum0 + 14'd64 : sum0;
        s2_d.diff  = (diff0[7:6] == 2'b11) ? diff0 - 14'd64 : diff0;
    end

    logic [KCEX_W-1:0] kcex_d;
    logic              wr_ok;
    logic              wr_en;

    // S3: pick the path and clamp to the top key or floor to zero
    always_comb begin
        if (s2_q.carry)
            kcex_d = KCEX_MAX;
        else if (s2_q.add)
            kcex_d = s2_q.sum[13] ? KCEX_MAX : s2_q.sum[KCEX_W-1:0];
        else
            kcex_d = s2_q.diff[13] ? '0 : s2_q.diff[KCEX_W-1:0];
    end

`ifdef JT51_PM_SAT_FLAG_EN
    logic sat_d;
    assign sat_d = s2_q.carry ||
                   (s2_q.add ? s2_q.sum[13] : s2_q.diff[13]);
`endif

    assign wr_ok = ({1'b0, s2_q.ch} < NCH);
    assign wr_en = cen && s2_q.valid && wr_ok;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= '0;
            s2_q      <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            kcex      <= '0;
`ifdef JT51_PM_SAT_FLAG_EN
            sat       <= 1'b0;
`endif
        end else if (cen) begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            out_valid <= s2_q.valid;
            out_ch    <= s2_q.ch[CHW-1:0];
            kcex      <= kcex_d;
`ifdef JT51_PM_SAT_FLAG_EN
            sat       <= sat_d;
`endif
        end
    end

    jt51_pm_buf #(
        .CHANNELS (CHANNELS)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_ch   (s2_q.ch[CHW-1:0]),
        .wr_kcex (kcex_d),
`ifdef JT51_PM_SAT_FLAG_EN
        .wr_sat  (sat_d),
        .rd_sat  (rd_sat),
`endif
        .rd_ch   (rd_ch),
        .rd_kcex (rd_kcex)
    );

endmodule

// File: tb/tb_jt51_pm_pipe.sv
// tb_jt51_pm_pipe: directed checks of jt51_pm_pipe with six buffered
// channels, so channel codes 6 and 7 exercise the out-of-range paths.
module tb_jt51_pm_pipe;

    localparam int CHANNELS = 6;
    localparam int CHW      = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cen;
    logic        in_valid;
    logic [2:0]  in_ch;
    logic [6:0]  kc_in;
    logic [5:0]  kf_in;
    logic [7:0]  lfo_pm;
    logic [2:0]  pms;
    logic        out_valid;
    logic [2:0]  out_ch;
    logic [12:0] kcex;
    logic [2:0]  rd_ch;
    logic [12:0] rd_kcex;
`ifdef JT51_PM_SAT_FLAG_EN
    logic        sat;
    logic        rd_sat;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    jt51_pm_pipe #(
        .CHANNELS (CHANNELS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cen       (cen),
        .in_valid  (in_valid),
        .in_ch     (in_ch),
        .kc_in     (kc_in),
        .kf_in     (kf_in),
        .lfo_pm    (lfo_pm),
        .pms       (pms),
        .out_valid (out_valid),
        .out_ch    (out_ch),
        .kcex      (kcex),
`ifdef JT51_PM_SAT_FLAG_EN
        .sat       (sat),
        .rd_sat    (rd_sat),
`endif
        .rd_ch     (rd_ch),
        .rd_kcex   (rd_kcex)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // present one slot, let it drain, check outputs and the buffer
    task automatic run(input string tag, input logic [2:0] ch,
                       input logic [6:0] kc, input logic [5:0] kf,
                       input logic [7:0] lfo, input logic [2:0] p,
                       input logic [12:0] exp, input logic exp_sat,
                       input logic in_rng);
        in_valid = 1'b1;
        in_ch    = ch;
        kc_in    = kc;
        kf_in    = kf;
        lfo_pm   = lfo;
        pms      = p;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".ch"}, 32'(out_ch), 32'(ch));
        chk({tag, ".kcex"}, 32'(kcex), 32'(exp));
`ifdef JT51_PM_SAT_FLAG_EN
        chk({tag, ".sat"}, 32'(sat), 32'(exp_sat));
`endif
        rd_ch = ch;
        #1;
        chk({tag, ".rd"}, 32'(rd_kcex), in_rng ? 32'(exp) : 32'd0);
        @(negedge clk);
        chk({tag, ".idle"}, 32'(out_valid), 32'd0);
    endtask

    logic [12:0] buf_exp [6];

    initial begin
        rst_n    = 1'b1;
        cen      = 1'b1;
        in_valid = 1'b0;
        in_ch    = '0;
        kc_in    = '0;
        kf_in    = '0;
        lfo_pm   = '0;
        pms      = '0;
        rd_ch    = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.ch", 32'(out_ch), 32'd0);
        chk("reset.kcex", 32'(kcex), 32'd0);
        chk("reset.rd", 32'(rd_kcex), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run("zero",    3'd0, 7'h00, 6'd0,  8'h00, 3'd5, 13'h0000, 1'b0, 1'b1);
        run("add_gap", 3'd1, 7'h02, 6'd0,  8'h7F, 3'd7, 13'h033C, 1'b0, 1'b1);
        run("add_sat", 3'd2, 7'h7E, 6'd63, 8'h7F, 3'd7, 13'h1FBF, 1'b1, 1'b1);
        run("sub_flr", 3'd3, 7'h00, 6'd0,  8'h80, 3'd7, 13'h0000, 1'b1, 1'b1);
        run("cry_add", 3'd4, 7'h7F, 6'd0,  8'h01, 3'd1, 13'h1FBF, 1'b1, 1'b1);
        run("cry_sub", 3'd5, 7'h7F, 6'd0,  8'h9C, 3'd7, 13'h1FBF, 1'b1, 1'b1);
        run("kc_clean",3'd0, 7'h73, 6'd0,  8'h00, 3'd5, 13'h1D00, 1'b0, 1'b1);
        run("pms_off", 3'd1, 7'h45, 6'd10, 8'hCE, 3'd0, 13'h114A, 1'b0, 1'b1);
        run("sub_kf",  3'd2, 7'h41, 6'd20, 8'hC0, 3'd5, 13'h1014, 1'b0, 1'b1);
        run("sub_gap", 3'd3, 7'h44, 6'd0,  8'hE0, 3'd6, 13'h1080, 1'b0, 1'b1);
        run("sub_ext", 3'd4, 7'h42, 6'd0,  8'h81, 3'd7, 13'h0E04, 1'b0, 1'b1);
        run("add_kf",  3'd5, 7'h20, 6'd40, 8'h64, 3'd4, 13'h085A, 1'b0, 1'b1);
        run("mag_sat", 3'd0, 7'h20, 6'd0,  8'h80, 3'd5, 13'h0741, 1'b0, 1'b1);
        run("oor_ch",  3'd6, 7'h10, 6'd5,  8'hFD, 3'd1, 13'h0405, 1'b0, 1'b0);

        buf_exp = '{13'h0741, 13'h114A, 13'h1014,
                    13'h1080, 13'h0E04, 13'h085A};
        for (int c = 0; c < 6; c++) begin
            rd_ch = 3'(c);
            #1;
            chk("buf.sweep", 32'(rd_kcex), 32'(buf_exp[c]));
        end
        rd_ch = 3'd7;
        #1;
        chk("buf.oor7", 32'(rd_kcex), 32'd0);
`ifdef JT51_PM_SAT_FLAG_EN
        rd_ch = 3'd2;
        #1;
        chk("sticky.ch2", 32'(rd_sat), 32'd1);
        rd_ch = 3'd1;
        #1;
        chk("sticky.ch1", 32'(rd_sat), 32'd0);
`endif
        @(negedge clk);

        // back-to-back slots with cen toggling, reset dropped at slot 5
        for (int i = 0; i < 8; i++) begin
            if (i == 5) begin
                rst_n = 1'b0;
                #1;
                chk("rst.valid", 32'(out_valid), 32'd0);
                chk("rst.kcex", 32'(kcex), 32'd0);
                chk("rst.ch", 32'(out_ch), 32'd0);
                for (int c = 0; c < 8; c++) begin
                    rd_ch = 3'(c);
                    #1;
                    chk("rst.buf", 32'(rd_kcex), 32'd0);
                end
                break;
            end
            cen      = 1'b1;
            in_valid = 1'b1;
            in_ch    = 3'(i);
            kc_in    = {3'(i), 4'h0};
            kf_in    = 6'(i);
            lfo_pm   = 8'h00;
            pms      = 3'd0;
            @(negedge clk);
            chk("b2b.valid", 32'(out_valid), 32'(i >= 2));
            if (i >= 2) begin
                chk("b2b.kcex", 32'(kcex), 32'(((i - 2) << 10) | (i - 2)));
                chk("b2b.ch", 32'(out_ch), 32'(i - 2));
            end
            cen = 1'b0;
            @(negedge clk);
            chk("hold.valid", 32'(out_valid), 32'(i >= 2));
            if (i >= 2) begin
                chk("hold.kcex", 32'(kcex), 32'(((i - 2) << 10) | (i - 2)));
            end
        end
        in_valid = 1'b0;
        cen      = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post.idle", 32'(out_valid), 32'd0);
        end
`ifdef JT51_PM_SAT_FLAG_EN
        rd_ch = 3'd2;
        #1;
        chk("post.sticky", 32'(rd_sat), 32'd0);
`endif
        run("post_rst", 3'd0, 7'h73, 6'd0, 8'h00, 3'd5, 13'h1D00, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
